// File: rtl/product_to_bcd_pkg.sv
// Shared definitions for the signed-product to BCD converter.
// Optional feature macro: PRODUCT_TO_BCD_BLANK_EN (leading-zero blanking helper).
package product_to_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    localparam int PROD_W = 16;
    localparam int DIGITS = 5;
    localparam int ITER   = 16;
    localparam int BCD_W  = DIGITS * 4;
    localparam int CNT_W  = 5;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Replace leading zero digits with BLANK_CODE; the units digit always stays visible.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = d;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (d[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/product_to_bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added before the shift.
module bcd_add3_cell (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Pure combinational correction; inputs never exceed 9 so the sum fits 4 bits.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/product_to_bcd.sv
// Converts a signed 16-bit product to sign + five BCD digits using double-dabble,
// one shift per cycle for 16 cycles.
// Optional feature macro: PRODUCT_TO_BCD_BLANK_EN (leading zero digits shown as 4'hF).
//
// state   | meaning
// IDLE    | waiting for start; result outputs hold the last value
// CONVERT | one add-3/shift iteration per cycle, counter runs 16 -> 0
// FINISH  | publish sign/bcd, pulse done, return to IDLE
module product_to_bcd
    import product_to_bcd_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PROD_W-1:0]   product,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                sign,
    output logic [BCD_W-1:0]    bcd
);

    localparam logic [CNT_W-1:0] C_ITER = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]    r_cnt;
    logic [PROD_W-1:0]   r_mag;
    logic [BCD_W-1:0]    r_digits;
    logic                r_sign_lat;
    logic                r_sign;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_done;

    logic                w_load;
    logic                w_iter;
    logic                w_finish;
    logic                w_busy;
    logic [PROD_W-1:0]   w_abs;
    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W+PROD_W-1:0] w_shift;

    // One correction cell per digit of the working register.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3_cell u_add3 (
                .i_digit (r_digits[g*4 +: 4]),
                .o_digit (w_adj[g*4 +: 4])
            );
        end
    endgenerate

    // Magnitude of the two's-complement input; 0x8000 maps to 32768 unchanged.
    always_comb begin
        w_abs   = product[PROD_W-1] ? (~product + 16'd1) : product;
        w_shift = {w_adj, r_mag} << 1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the counter's terminal value ends the conversion.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_CONVERT;
            ST_CONVERT: if (r_cnt == C_LAST) w_state_nxt = ST_FINISH;
            ST_FINISH:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode. busy skips the load cycle so it spans exactly 16 cycles.
    always_comb begin
        w_load   = 1'b0;
        w_iter   = 1'b0;
        w_finish = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            ST_IDLE:    w_load = start;
            ST_CONVERT: begin
                w_iter = 1'b1;
                w_busy = (r_cnt != C_ITER);
            end
            ST_FINISH:  begin
                w_finish = 1'b1;
                w_busy   = 1'b1;
            end
            default:    w_load = 1'b0;
        endcase
    end

    // Datapath: load operands, shift during CONVERT, publish the result in FINISH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_mag      <= '0;
            r_digits   <= '0;
            r_sign_lat <= 1'b0;
            r_sign     <= 1'b0;
            r_bcd      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_sign_lat <= product[PROD_W-1];
                r_mag      <= w_abs;
                r_digits   <= '0;
                r_cnt      <= C_ITER;
            end else if (w_iter) begin
                r_digits <= w_shift[BCD_W+PROD_W-1:PROD_W];
                r_mag    <= w_shift[PROD_W-1:0];
                r_cnt    <= r_cnt - C_LAST;
            end else if (w_finish) begin
                r_done <= 1'b1;
                r_sign <= r_sign_lat;
`ifdef PRODUCT_TO_BCD_BLANK_EN
                r_bcd  <= blank_leading(r_digits);
`else
                r_bcd  <= r_digits;
`endif
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign sign = r_sign;
    assign bcd  = r_bcd;

endmodule
